hazard_stall_unit: RTL and testbench

Pipeline hazard controller for the 64-bit 5-stage core; it generates `PCWrite` and the matching stall, bubble and flush controls for the PC register and the IF/ID, ID/EX and EX/MEM pipeline registers. Sources of control:
- load-use hazards detected in ID;
- taken branches resolved in MEM;
- multi-cycle data-memory waits.

It also holds fetch for one cycle after reset and keeps saturating hazard-event counters for debug.

---
 rtl/pipeline_pkg.sv | 22 ++
 rtl/sat_counter.sv | 36 +++
 rtl/hazard_stall_unit.sv | 127 ++++++++++++
 tb/tb_hazard_stall_unit.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline control blocks: FSM state type,
// the hard-wired zero register index and default widths.
package pipeline_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } hazard_state_t;

    localparam logic [4:0] REG_X0        = 5'd0;
    localparam int         XLEN_DEFAULT  = 64;
    localparam int         CNT_W_DEFAULT = 32;

    // A source operand depends on the load only if it is really read and
    // names the same architectural register; x0 is never a real dependency.
    function automatic logic src_depends(input logic       use_src,
                                         input logic [4:0] rs,
                                         input logic [4:0] rd);
        return use_src && (rd != REG_X0) && (rs == rd);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear. Sticks at
// all-ones so a long debug session never sees a count roll back to zero.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    // Next value: increment only when enabled and not already saturated.
    always_comb begin
        count_next = count_reg;
        if (en && (count_reg != {CNT_W{1'b1}})) begin
            count_next = count_reg + CNT_ONE;
        end
    end

    // Counter register with synchronous clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/hazard_stall_unit.sv
// Hazard controller for the 5-stage core: generates PC / IF/ID write
// enables, ID/EX bubble, pipeline flushes and freeze, plus debug counters.
// Priority in RUN: memory freeze > taken-branch flush > load-use stall.
module hazard_stall_unit
    import pipeline_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_rd,
    input  logic [4:0]       IFID_rs1,
    input  logic [4:0]       IFID_rs2,
    input  logic             IFID_use_rs1,
    input  logic             IFID_use_rs2,
    input  logic             EXMEM_branch_taken,
    input  logic             mem_busy,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEX_bubble,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic             EXMEM_flush,
    output logic             pipe_hold,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    // XLEN only documents the datapath this unit serves; it shapes nothing here.
    if (XLEN < 32) begin : g_xlen_narrow
    end

    localparam int N_CNT    = 3;
    localparam int IDX_STALL  = 0;
    localparam int IDX_FLUSH  = 1;
    localparam int IDX_FREEZE = 2;

    hazard_state_t state_reg;

    logic             run_active;
    logic             load_use;
    logic             freeze_evt;
    logic             flush_evt;
    logic             stall_evt;
    logic [N_CNT-1:0] cnt_en;
    logic [CNT_W-1:0] cnt_val [N_CNT];

    // INIT lasts exactly one cycle after reset release, then RUN forever.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= INIT;
        end else begin
            case (state_reg)
                INIT:    state_reg <= RUN;
                RUN:     state_reg <= RUN;
                default: state_reg <= INIT;
            endcase
        end
    end

    // Hazard classification in strict priority order; held in reset looks like INIT.
    always_comb begin
        run_active = reset && (state_reg == RUN);
        load_use   = IDEX_MemRead &&
                     (src_depends(IFID_use_rs1, IFID_rs1, IDEX_rd) ||
                      src_depends(IFID_use_rs2, IFID_rs2, IDEX_rd));
        freeze_evt = run_active && mem_busy;
        flush_evt  = run_active && !mem_busy && EXMEM_branch_taken;
        stall_evt  = run_active && !mem_busy && !EXMEM_branch_taken && load_use;
    end

    // Control outputs: combinational from the inputs once running.
    always_comb begin
        PCWrite     = 1'b0;
        IFIDWrite   = 1'b0;
        IDEX_bubble = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        EXMEM_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (!run_active) begin
            // Hold PC at 0 and flush IF/ID so address 0 is fetched cleanly.
            IFID_flush = 1'b1;
        end else if (freeze_evt) begin
            pipe_hold = 1'b1;
        end else if (flush_evt) begin
            PCWrite     = 1'b1;
            IFIDWrite   = 1'b1;
            IFID_flush  = 1'b1;
            IDEX_flush  = 1'b1;
            EXMEM_flush = 1'b1;
        end else if (stall_evt) begin
            IDEX_bubble = 1'b1;
        end else begin
            PCWrite   = 1'b1;
            IFIDWrite = 1'b1;
        end
    end

    // Event enables feeding the debug counters.
    always_comb begin
        cnt_en             = '0;
        cnt_en[IDX_STALL]  = stall_evt;
        cnt_en[IDX_FLUSH]  = flush_evt;
        cnt_en[IDX_FREEZE] = freeze_evt;
    end

    genvar gi;
    for (gi = 0; gi < N_CNT; gi++) begin : g_cnt
        sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .clear_n (reset),
            .en      (cnt_en[gi]),
            .count   (cnt_val[gi])
        );
    end

    assign stall_cnt  = cnt_val[IDX_STALL];
    assign flush_cnt  = cnt_val[IDX_FLUSH];
    assign freeze_cnt = cnt_val[IDX_FREEZE];

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Randomized + directed bench for hazard_stall_unit. Two instances share the
// stimulus: one with 32-bit counters, one with 4-bit counters for saturation.
module tb_hazard_stall_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       IDEX_MemRead;
    logic [4:0] IDEX_rd;
    logic [4:0] IFID_rs1;
    logic [4:0] IFID_rs2;
    logic       IFID_use_rs1;
    logic       IFID_use_rs2;
    logic       EXMEM_branch_taken;
    logic       mem_busy;

    logic        pcw_a, ifidw_a, bub_a, ifl_a, idfl_a, exfl_a, hold_a;
    logic [31:0] stall_a, flush_a, freeze_a;
    logic        pcw_b, ifidw_b, bub_b, ifl_b, idfl_b, exfl_b, hold_b;
    logic [3:0]  stall_b, flush_b, freeze_b;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state: whether the unit should be running, and
    // plain integer event tallies since the last reset.
    bit model_run = 1'b0;
    int model_stalls  = 0;
    int model_flushes = 0;
    int model_freezes = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.XLEN(64), .CNT_W(32)) dut (
        .clk(clk), .reset(reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
        .EXMEM_branch_taken(EXMEM_branch_taken), .mem_busy(mem_busy),
        .PCWrite(pcw_a), .IFIDWrite(ifidw_a), .IDEX_bubble(bub_a),
        .IFID_flush(ifl_a), .IDEX_flush(idfl_a), .EXMEM_flush(exfl_a),
        .pipe_hold(hold_a),
        .stall_cnt(stall_a), .flush_cnt(flush_a), .freeze_cnt(freeze_a)
    );

    hazard_stall_unit #(.XLEN(64), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset),
        .IDEX_MemRead(IDEX_MemRead), .IDEX_rd(IDEX_rd),
        .IFID_rs1(IFID_rs1), .IFID_rs2(IFID_rs2),
        .IFID_use_rs1(IFID_use_rs1), .IFID_use_rs2(IFID_use_rs2),
        .EXMEM_branch_taken(EXMEM_branch_taken), .mem_busy(mem_busy),
        .PCWrite(pcw_b), .IFIDWrite(ifidw_b), .IDEX_bubble(bub_b),
        .IFID_flush(ifl_b), .IDEX_flush(idfl_b), .EXMEM_flush(exfl_b),
        .pipe_hold(hold_b),
        .stall_cnt(stall_b), .flush_cnt(flush_b), .freeze_cnt(freeze_b)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s txn=%0d got=%0h exp=%0h", tag, n_txn, got, exp);
        end
    endtask

    task automatic set_in(input logic rst, input logic mr, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u1, input logic u2, input logic br, input logic busy);
        reset = rst; IDEX_MemRead = mr; IDEX_rd = rd;
        IFID_rs1 = rs1; IFID_rs2 = rs2; IFID_use_rs1 = u1; IFID_use_rs2 = u2;
        EXMEM_branch_taken = br; mem_busy = busy;
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // One clock cycle: predict, compare mid-cycle, then advance the model.
    // Event class: 0 none/init, 1 freeze, 2 flush, 3 stall, 4 normal.
    task automatic step();
        logic [6:0] exp_ctrl;
        logic [6:0] got_a, got_b;
        int         ev;
        bit         hazard;
        @(negedge clk);
        n_txn++;
        hazard = IDEX_MemRead && (IDEX_rd != 5'd0) &&
                 ((IFID_use_rs1 && IFID_rs1 == IDEX_rd) ||
                  (IFID_use_rs2 && IFID_rs2 == IDEX_rd));
        // order: PCWrite IFIDWrite bubble IFID_fl IDEX_fl EXMEM_fl hold
        if (!reset || !model_run) begin
            ev = 0; exp_ctrl = 7'b0001000;
        end else if (mem_busy) begin
            ev = 1; exp_ctrl = 7'b0000001;
        end else if (EXMEM_branch_taken) begin
            ev = 2; exp_ctrl = 7'b1101110;
        end else if (hazard) begin
            ev = 3; exp_ctrl = 7'b0010000;
        end else begin
            ev = 4; exp_ctrl = 7'b1100000;
        end
        got_a = {pcw_a, ifidw_a, bub_a, ifl_a, idfl_a, exfl_a, hold_a};
        got_b = {pcw_b, ifidw_b, bub_b, ifl_b, idfl_b, exfl_b, hold_b};
        $display("txn %0d rst=%0b mr=%0b rd=%0d rs1=%0d/%0b rs2=%0d/%0b br=%0b busy=%0b ctrl=%b cnt=%0d/%0d/%0d",
                 n_txn, reset, IDEX_MemRead, IDEX_rd, IFID_rs1, IFID_use_rs1, IFID_rs2,
                 IFID_use_rs2, EXMEM_branch_taken, mem_busy, got_a, stall_a, flush_a, freeze_a);
        check_eq("ctrl32", {57'd0, got_a}, {57'd0, exp_ctrl});
        check_eq("ctrl4", {57'd0, got_b}, {57'd0, exp_ctrl});
        check_eq("stall32", {32'd0, stall_a}, 64'(model_stalls));
        check_eq("flush32", {32'd0, flush_a}, 64'(model_flushes));
        check_eq("freeze32", {32'd0, freeze_a}, 64'(model_freezes));
        check_eq("stall4", {60'd0, stall_b}, 64'(sat(model_stalls, 15)));
        check_eq("flush4", {60'd0, flush_b}, 64'(sat(model_flushes, 15)));
        check_eq("freeze4", {60'd0, freeze_b}, 64'(sat(model_freezes, 15)));
        @(posedge clk);
        if (!reset) begin
            model_run = 1'b0;
            model_stalls = 0; model_flushes = 0; model_freezes = 0;
        end else if (!model_run) begin
            model_run = 1'b1;
        end else begin
            if (ev == 1) model_freezes++;
            if (ev == 2) model_flushes++;
            if (ev == 3) model_stalls++;
        end
        #1;
    endtask

    initial begin
        // Reset held three cycles, then INIT, then RUN.
        set_in(1'b0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();

        // Load-use hit through rs2, then idle, then same with rd = x0.
        set_in(1'b1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0);
        step();
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("lu_count", {32'd0, stall_a}, 64'd1);
        set_in(1'b1, 1, 5'd0, 5'd0, 5'd0, 1, 1, 0, 0);
        step();

        // Branch together with a load-use hazard: branch wins.
        set_in(1'b1, 1, 5'd5, 5'd5, 5'd0, 1, 0, 1, 0);
        step();

        // Four frozen cycles with a pending branch, then the flush lands.
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 1, 1);
        repeat (4) step();
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("freeze_total", {32'd0, freeze_a}, 64'd4);

        // Twenty stall cycles saturate the 4-bit counter.
        set_in(1'b1, 1, 5'd9, 5'd9, 5'd1, 1, 0, 0, 0);
        repeat (20) step();
        set_in(1'b1, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        check_eq("sat_hold", {60'd0, stall_b}, 64'd15);

        // Reset asserted in the middle of a stall.
        set_in(1'b1, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0);
        step();
        set_in(1'b0, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0);
        step();
        check_eq("rst_cnt", {32'd0, stall_a}, 64'd0);
        set_in(1'b1, 1, 5'd3, 5'd3, 5'd0, 1, 0, 0, 0);
        step();
        step();

        // Random traffic biased towards small register numbers for collisions.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(0, 99) >= 3),
                   $urandom_range(0, 1),
                   5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   5'($urandom_range(0, 3)),
                   $urandom_range(0, 1),
                   $urandom_range(0, 1),
                   ($urandom_range(0, 99) < 20),
                   ($urandom_range(0, 99) < 25));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
